// File: rtl/window_reader_pkg.sv
// Shared widths and issue-kind encoding for the window buffer read client.
// Widths come from the parameters.vh macros when defined, otherwise defaults.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MATCH_PU_WIDTH
`define MATCH_PU_WIDTH 4
`endif

package window_reader_pkg;
    localparam int unsigned ADDR_WIDTH     = `ADDR_WIDTH;
    localparam int unsigned MATCH_PU_WIDTH = `MATCH_PU_WIDTH;
    localparam int unsigned DATA_WIDTH     = MATCH_PU_WIDTH * 8;

    typedef enum logic [1:0] {
        ISSUE_IDLE,
        ISSUE_REAL,
        ISSUE_BUBBLE
    } issue_t;
endpackage

// File: rtl/window_reader_sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
    localparam int unsigned COUNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (count == '0);
    assign full     = (count == COUNT_WIDTH'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/window_reader.sv
// Read-side client of the window buffer: issues real/bubble reads, tracks them in a
// shadow pipeline that advances with read_enable, and queues results under credit control.
module window_reader
    import window_reader_pkg::*;
#(
    parameter int unsigned NBPIPE     = 3,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  wb_read_enable,
    output logic [ADDR_WIDTH-1:0] wb_read_address,
    input  logic                  wb_read_unsafe,
    input  logic [DATA_WIDTH-1:0] wb_read_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_unsafe,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic                  busy
);
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + 1 + TAG_WIDTH;
    localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    logic [NBPIPE:0]        stage_valid;
    logic [TAG_WIDTH-1:0]   stage_tag [NBPIPE+1];
    logic                   fresh;
    logic [ADDR_WIDTH-1:0]  last_address;
    issue_t                 issue;
    logic                   capture;
    logic [31:0]            inflight;
    logic [31:0]            occupancy;
    logic [COUNT_WIDTH-1:0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_WIDTH-1:0] push_entry;
    logic [ENTRY_WIDTH-1:0] head_entry;

    // fresh stops a parked last-stage entry from being captured twice while the pipe is idle.
    assign capture = stage_valid[NBPIPE] && fresh;

    always_comb begin
        inflight = {31'b0, capture};
        for (int unsigned i = 0; i < NBPIPE; i++) begin
            inflight = inflight + {31'b0, stage_valid[i]};
        end
    end

    assign occupancy = inflight + 32'(fifo_count);
    assign req_ready = !rst && !fifo_full && (occupancy < 32'(FIFO_DEPTH));
    assign busy      = (inflight != '0) || (fifo_count != '0);

    always_comb begin
        issue = ISSUE_IDLE;
        if (req_valid && req_ready) begin
            issue = ISSUE_REAL;
        end else if (!rst && (|stage_valid[NBPIPE-1:0])) begin
            issue = ISSUE_BUBBLE;
        end
    end

    assign wb_read_enable  = (issue != ISSUE_IDLE);
    assign wb_read_address = (issue == ISSUE_REAL) ? req_address : last_address;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid  <= '0;
            fresh        <= 1'b0;
            last_address <= '0;
        end else if (wb_read_enable) begin
            stage_valid <= {stage_valid[NBPIPE-1:0], issue == ISSUE_REAL};
            fresh       <= stage_valid[NBPIPE-1];
            if (issue == ISSUE_REAL) last_address <= req_address;
        end else if (capture) begin
            fresh <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_read_enable) begin
            stage_tag[0] <= req_tag;
            for (int unsigned i = 1; i <= NBPIPE; i++) begin
                stage_tag[i] <= stage_tag[i-1];
            end
        end
    end

    assign push_entry = {wb_read_data, wb_read_unsafe, stage_tag[NBPIPE]};

    sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .pop       (res_ready),
        .push_data (push_entry),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid                        = !fifo_empty;
    assign {res_data, res_unsafe, res_tag}  = head_entry;
endmodule

// File: tb/tb_window_reader.sv
// Directed bench for window_reader with behavioural window-buffer models
// (FIFO_DEPTH 8 for instance a, FIFO_DEPTH 4 for instance b).
module tb_window_reader;
    import window_reader_pkg::*;

    localparam int unsigned NBPIPE = 3;

    logic clk;
    logic rst;

    logic                  req_valid_a, req_ready_a, wb_en_a, wb_unsafe_a;
    logic                  res_valid_a, res_ready_a, res_unsafe_a, busy_a;
    logic [ADDR_WIDTH-1:0] req_addr_a, wb_addr_a;
    logic [7:0]            req_tag_a, res_tag_a;
    logic [DATA_WIDTH-1:0] wb_data_a, res_data_a;

    logic                  req_valid_b, req_ready_b, wb_en_b, wb_unsafe_b;
    logic                  res_valid_b, res_ready_b, res_unsafe_b, busy_b;
    logic [ADDR_WIDTH-1:0] req_addr_b, wb_addr_b;
    logic [7:0]            req_tag_b, res_tag_b;
    logic [DATA_WIDTH-1:0] wb_data_b, res_data_b;

    int n_asserts = 0;
    int n_fail    = 0;

    function automatic logic [DATA_WIDTH-1:0] model_data(input logic [ADDR_WIDTH-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic logic model_unsafe(input logic [ADDR_WIDTH-1:0] a);
        return (a == 16'h0010);
    endfunction

    window_reader #(.NBPIPE(NBPIPE), .TAG_WIDTH(8), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_address(req_addr_a), .req_tag(req_tag_a),
        .wb_read_enable(wb_en_a), .wb_read_address(wb_addr_a),
        .wb_read_unsafe(wb_unsafe_a), .wb_read_data(wb_data_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a),
        .res_data(res_data_a), .res_unsafe(res_unsafe_a), .res_tag(res_tag_a),
        .busy(busy_a)
    );

    window_reader #(.NBPIPE(NBPIPE), .TAG_WIDTH(8), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_address(req_addr_b), .req_tag(req_tag_b),
        .wb_read_enable(wb_en_b), .wb_read_address(wb_addr_b),
        .wb_read_unsafe(wb_unsafe_b), .wb_read_data(wb_data_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b),
        .res_data(res_data_b), .res_unsafe(res_unsafe_b), .res_tag(res_tag_b),
        .busy(busy_b)
    );

    // Window buffer models: address pipeline advancing only on read_enable.
    logic [ADDR_WIDTH-1:0] mpipe_a [NBPIPE+1];
    logic [ADDR_WIDTH-1:0] mpipe_b [NBPIPE+1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NBPIPE; i++) mpipe_a[i] <= '0;
        end else if (wb_en_a) begin
            mpipe_a[0] <= wb_addr_a;
            for (int i = 1; i <= NBPIPE; i++) mpipe_a[i] <= mpipe_a[i-1];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j <= NBPIPE; j++) mpipe_b[j] <= '0;
        end else if (wb_en_b) begin
            mpipe_b[0] <= wb_addr_b;
            for (int j = 1; j <= NBPIPE; j++) mpipe_b[j] <= mpipe_b[j-1];
        end
    end

    assign wb_data_a   = model_data(mpipe_a[NBPIPE]);
    assign wb_unsafe_a = model_unsafe(mpipe_a[NBPIPE]);
    assign wb_data_b   = model_data(mpipe_b[NBPIPE]);
    assign wb_unsafe_b = model_unsafe(mpipe_b[NBPIPE]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_a = 1'b0; req_addr_a = '0; req_tag_a = '0; res_ready_a = 1'b0;
        req_valid_b = 1'b0; req_addr_b = '0; req_tag_b = '0; res_ready_b = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready_a, 0);
        chk("rst_wb_en", wb_en_a, 0);
        chk("rst_wb_addr", wb_addr_a, 0);
        chk("rst_res_valid", res_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_b_req_ready", req_ready_b, 0);
        chk("rst_b_res_valid", res_valid_b, 0);

        cyc(); rst = 1'b0; res_ready_a = 1'b1; #1;
        chk("idle_req_ready", req_ready_a, 1);

        // Isolated request
        cyc(); req_valid_a = 1'b1; req_addr_a = 16'h0100; req_tag_a = 8'h5A; #1;
        chk("iso_req_ready", req_ready_a, 1);
        chk("iso_wb_en", wb_en_a, 1);
        chk("iso_wb_addr", wb_addr_a, 16'h0100);
        for (int k = 1; k <= 4; k++) begin
            cyc(); req_valid_a = 1'b0; #1;
            chk("iso_bubble_en", wb_en_a, (k <= 3) ? 1 : 0);
            if (k <= 3) chk("iso_bubble_addr", wb_addr_a, 16'h0100);
            chk("iso_early_valid", res_valid_a, 0);
        end
        cyc(); #1;
        chk("iso_res_valid", res_valid_a, 1);
        chk("iso_res_tag", res_tag_a, 8'h5A);
        chk("iso_res_data", res_data_a, model_data(16'h0100));
        chk("iso_res_unsafe", res_unsafe_a, 0);
        cyc(); #1;
        chk("iso_after_valid", res_valid_a, 0);
        chk("iso_after_busy", busy_a, 0);

        // Burst of 8 back-to-back requests
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (c < 8) begin
                req_valid_a = 1'b1; req_addr_a = 16'h0200 + 16'(c); req_tag_a = 8'h10 + 8'(c);
            end else begin
                req_valid_a = 1'b0;
            end
            #1;
            if (c < 8) chk("burst_req_ready", req_ready_a, 1);
            chk("burst_res_valid", res_valid_a, (c >= 5 && c <= 12) ? 1 : 0);
            if (c >= 5 && c <= 12) begin
                chk("burst_res_tag", res_tag_a, 8'h10 + 8'(c - 5));
                chk("burst_res_data", res_data_a, model_data(16'h0200 + 16'(c - 5)));
            end
        end

        // Unsafe flag; trailing bubbles re-read the unsafe address
        for (int c = 0; c < 9; c++) begin
            cyc();
            req_valid_a = (c < 2);
            req_addr_a  = (c == 0) ? 16'h0300 : 16'h0010;
            req_tag_a   = (c == 0) ? 8'hA1 : 8'hA2;
            #1;
            if (c >= 2 && c <= 3) chk("unsafe_bubble_addr", wb_addr_a, 16'h0010);
            if (c == 5) begin
                chk("unsafe_r0_valid", res_valid_a, 1);
                chk("unsafe_r0_tag", res_tag_a, 8'hA1);
                chk("unsafe_r0_flag", res_unsafe_a, 0);
                chk("unsafe_r0_data", res_data_a, model_data(16'h0300));
                chk("unsafe_idle_en", wb_en_a, 0);
            end else if (c == 6) begin
                chk("unsafe_r1_valid", res_valid_a, 1);
                chk("unsafe_r1_tag", res_tag_a, 8'hA2);
                chk("unsafe_r1_flag", res_unsafe_a, 1);
                chk("unsafe_r1_data", res_data_a, model_data(16'h0010));
            end else if (c >= 7) begin
                chk("unsafe_no_bubble_result", res_valid_a, 0);
            end
        end
        chk("unsafe_busy", busy_a, 0);

        // Fill the depth-8 FIFO, then push and pop in the same cycle
        res_ready_a = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            req_valid_a = (i < 10);
            req_addr_a  = 16'h0400 + 16'(i);
            req_tag_a   = 8'h40 + 8'(i);
            #1;
            if (i < 10) chk("full_req_ready", req_ready_a, (i < 8) ? 1 : 0);
        end
        chk("full_res_valid", res_valid_a, 1);
        chk("full_head_tag", res_tag_a, 8'h40);
        chk("full_busy", busy_a, 1);
        chk("full_req_ready_idle", req_ready_a, 0);
        cyc(); res_ready_a = 1'b1; #1;
        chk("pp_pop_tag", res_tag_a, 8'h40);
        chk("pp_pop_not_counted", req_ready_a, 0);
        cyc(); res_ready_a = 1'b0; req_valid_a = 1'b1; req_addr_a = 16'h04AA; req_tag_a = 8'h77; #1;
        chk("pp_refill_ready", req_ready_a, 1);
        chk("pp_head_tag", res_tag_a, 8'h41);
        for (int k = 0; k < 3; k++) begin
            cyc(); req_valid_a = 1'b0; #1;
            chk("pp_credit_full", req_ready_a, 0);
            chk("pp_bubble_addr", wb_addr_a, 16'h04AA);
        end
        cyc(); res_ready_a = 1'b1; #1;
        chk("pp_capture_ready", req_ready_a, 0);
        chk("pp_capture_en", wb_en_a, 0);
        chk("pp_capture_tag", res_tag_a, 8'h41);
        for (int j = 0; j < 7; j++) begin
            cyc(); #1;
            if (j == 0) chk("pp_after_ready", req_ready_a, 1);
            chk("pp_drain_valid", res_valid_a, 1);
            chk("pp_drain_tag", res_tag_a, (j < 6) ? 8'h42 + 8'(j) : 8'h77);
            chk("pp_drain_data", res_data_a, model_data((j < 6) ? 16'h0402 + 16'(j) : 16'h04AA));
        end
        cyc(); #1;
        chk("pp_end_valid", res_valid_a, 0);
        chk("pp_end_busy", busy_a, 0);

        // Reset with 3 requests in flight
        for (int c = 0; c < 3; c++) begin
            cyc(); req_valid_a = 1'b1; req_addr_a = 16'h0500 + 16'(c); req_tag_a = 8'h50 + 8'(c); #1;
            chk("rstb_req_ready", req_ready_a, 1);
        end
        cyc(); req_valid_a = 1'b0; rst = 1'b1; #1;
        chk("rstb_gated_ready", req_ready_a, 0);
        cyc(); #1;
        chk("rstb_res_valid", res_valid_a, 0);
        chk("rstb_busy", busy_a, 0);
        chk("rstb_req_ready_after", req_ready_a, 0);
        chk("rstb_wb_en", wb_en_a, 0);
        cyc(); rst = 1'b0; #1;
        cyc(); req_valid_a = 1'b1; req_addr_a = 16'h0600; req_tag_a = 8'h66; #1;
        chk("rstb_new_ready", req_ready_a, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); req_valid_a = 1'b0; #1;
            chk("rstb_no_stale", res_valid_a, 0);
        end
        cyc(); #1;
        chk("rstb_new_valid", res_valid_a, 1);
        chk("rstb_new_tag", res_tag_a, 8'h66);
        chk("rstb_new_data", res_data_a, model_data(16'h0600));
        cyc(); #1;
        chk("rstb_new_busy", busy_a, 0);

        // Back-pressure on the depth-4 instance
        for (int i = 0; i < 9; i++) begin
            cyc();
            req_valid_b = (i < 7);
            req_addr_b  = 16'h0700 + 16'(i);
            req_tag_b   = 8'h70 + 8'(i);
            #1;
            if (i < 7) chk("bp_req_ready", req_ready_b, (i < 4) ? 1 : 0);
        end
        chk("bp_full_valid", res_valid_b, 1);
        chk("bp_full_tag", res_tag_b, 8'h70);
        chk("bp_full_busy", busy_b, 1);
        chk("bp_full_ready", req_ready_b, 0);
        res_ready_b = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) cyc();
            #1;
            chk("bp_drain_valid", res_valid_b, 1);
            chk("bp_drain_tag", res_tag_b, 8'h70 + 8'(j));
            chk("bp_drain_data", res_data_b, model_data(16'h0700 + 16'(j)));
        end
        cyc(); #1;
        chk("bp_end_valid", res_valid_b, 0);
        chk("bp_end_busy", busy_b, 0);
        chk("bp_end_ready", req_ready_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
